// File: rtl/rs_dec_syndrome_calc_param.sv
// Reed-Solomon syndrome calculator over GF(2^8) (poly 0x11D); o_ready 1 cycle after the last symbol strobe.
// Optional erasure substitution/counting when ERASURE_EN is defined; no backpressure, gaps in i_data_sync held.
module rs_dec_syndrome_calc_param #(
    parameter int NSYND     = 4,
    parameter int FRAME_LEN = 32,
    parameter int FCR       = 0,
    parameter int CNT_W     = 8
) (
    input  logic                 i_clk,
    input  logic                 i_res,
    input  logic                 i_frame_sync,
    input  logic [7:0]           i_data,
    input  logic                 i_data_sync,
`ifdef ERASURE_EN
    input  logic                 i_erasure,
    output logic [CNT_W-1:0]     o_eras_cnt,
    output logic                 o_eras_ovf,
`endif
    output logic [NSYND*8-1:0]   o_synd,
    output logic                 o_err_flag,
    output logic                 o_ready,
    output logic                 o_overrun,
    output logic                 o_busy
);

    typedef enum logic {S_IDLE = 1'b0, S_ACC = 1'b1} state_t;

    function automatic logic [7:0] f_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
    endfunction

    function automatic logic [7:0] f_alpha_pow(input int k);
        logic [7:0] p;
        p = 8'h01;
        for (int n = 0; n < (k % 255); n++) p = f_xtime(p);
        return p;
    endfunction

    // With c an elaboration constant this collapses to a fixed XOR network.
    function automatic logic [7:0] f_mul_const(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] col;
        logic [7:0] r;
        r   = 8'h00;
        col = c;
        for (int b = 0; b < 8; b++) begin
            if (a[b]) r = r ^ col;
            col = f_xtime(col);
        end
        return r;
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [7:0]           r_acc [NSYND];
    logic [7:0]           w_acc_nxt [NSYND];
    logic [NSYND*8-1:0]   w_synd_nxt;
    logic [NSYND*8-1:0]   r_synd;
    logic                 r_err;
    logic                 r_ready;
    logic                 r_ovr;
    logic [7:0]           w_sym;
    logic                 w_last;
    logic                 w_start;
    logic                 w_done;
    logic                 w_restart;
    logic                 w_absorb;

`ifdef ERASURE_EN
    logic [CNT_W-1:0]     r_era_cnt;
    logic [CNT_W-1:0]     w_era_nxt;
    logic [CNT_W-1:0]     r_eras_cnt;
    logic                 r_eras_ovf;

    assign w_sym      = i_erasure ? 8'h00 : i_data;
    assign w_era_nxt  = r_era_cnt + (i_erasure ? CNT_W'(1) : CNT_W'(0));
    assign o_eras_cnt = r_eras_cnt;
    assign o_eras_ovf = r_eras_ovf;
`else
    assign w_sym = i_data;
`endif

    for (genvar g = 0; g < NSYND; g++) begin : g_root
        localparam logic [7:0] ROOT = f_alpha_pow(FCR + g);
        assign w_acc_nxt[g]          = f_mul_const(r_acc[g], ROOT) ^ w_sym;
        assign w_synd_nxt[8*g +: 8]  = w_acc_nxt[g];
    end

    assign w_last = i_data_sync && (r_cnt == CNT_W'(FRAME_LEN - 1));

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_frame_sync) w_state_nxt = S_ACC;
            S_ACC:   if (w_last)       w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The final symbol wins over a coincident sync: the old frame completes.
    always_comb begin
        w_done    = (r_state == S_ACC) && w_last;
        w_restart = (r_state == S_ACC) && i_frame_sync && !w_last;
        w_start   = ((r_state == S_IDLE) && i_frame_sync) || w_restart;
        w_absorb  = (r_state == S_ACC) && i_data_sync && !w_restart;
        o_busy    = (r_state == S_ACC);
    end

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            r_cnt   <= '0;
            r_synd  <= '0;
            r_err   <= 1'b0;
            r_ready <= 1'b0;
            r_ovr   <= 1'b0;
            for (int g = 0; g < NSYND; g++) r_acc[g] <= 8'h00;
        end else begin
            r_ready <= w_done;
            r_ovr   <= w_restart;
            if (w_start) begin
                for (int g = 0; g < NSYND; g++) r_acc[g] <= i_data_sync ? w_sym : 8'h00;
                r_cnt <= i_data_sync ? CNT_W'(1) : CNT_W'(0);
            end else if (w_absorb) begin
                for (int g = 0; g < NSYND; g++) r_acc[g] <= w_acc_nxt[g];
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_done) begin
                r_synd <= w_synd_nxt;
                r_err  <= |w_synd_nxt;
            end
        end
    end

`ifdef ERASURE_EN
    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            r_era_cnt  <= '0;
            r_eras_cnt <= '0;
            r_eras_ovf <= 1'b0;
        end else begin
            if (w_start)
                r_era_cnt <= (i_data_sync && i_erasure) ? CNT_W'(1) : CNT_W'(0);
            else if (w_absorb)
                r_era_cnt <= w_era_nxt;
            if (w_done) begin
                r_eras_cnt <= w_era_nxt;
                r_eras_ovf <= (w_era_nxt > CNT_W'(NSYND));
            end
        end
    end
`endif

    assign o_synd     = r_synd;
    assign o_err_flag = r_err;
    assign o_ready    = r_ready;
    assign o_overrun  = r_ovr;

endmodule
